// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: drives a req/gnt/rvalid data-RAM port and the
// mem_busy / mem_stop_end stall handshake, with byte-lane steering and a watchdog.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_op_valid,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [4:0]        mem_rd,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic              ram_gnt,
  input  logic              ram_rvalid,
  input  logic [31:0]       ram_rdata,
  output logic              mem_busy,
  output logic              mem_stop_end,
  output logic [31:0]       load_data,
  output logic [4:0]        load_rd,
  output logic              load_wen,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [7:0]        wdog;
  logic              mis_q, tmo_q, wen_q;
  logic [31:0]       load_data_q;
  logic [4:0]        load_rd_q;

  logic              accept, mis_in, is_load_q, wdog_exp;
  logic              capture, abort;
  logic [7:0]        rbyte;
  logic [31:0]       load_ext;

  assign accept    = (state == S_IDLE) && mem_op_valid && (mem_op <= OP_SB);
  assign mis_in    = ((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'b00);
  assign is_load_q = (op_q == OP_LW) || (op_q == OP_LB) || (op_q == OP_LBU);
  assign wdog_exp  = (wdog == 8'(TIMEOUT - 1));

  // A genuine completion in the last allowed cycle wins over the watchdog abort.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    abort   = 1'b0;
    case (state)
      S_IDLE: if (accept) state_d = mis_in ? S_DONE : S_REQ;
      S_REQ: begin
        if (ram_gnt) begin
          if (!is_load_q) begin
            state_d = S_DONE;
          end else if (ram_rvalid) begin
            state_d = S_DONE;
            capture = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
        if (state_d != S_DONE && wdog_exp) begin
          state_d = S_DONE;
          abort   = 1'b1;
        end
      end
      S_WAIT: begin
        if (ram_rvalid) begin
          state_d = S_DONE;
          capture = 1'b1;
        end else if (wdog_exp) begin
          state_d = S_DONE;
          abort   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rbyte = ram_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    rbyte = ram_rdata[15:8];
      2'd2:    rbyte = ram_rdata[23:16];
      2'd3:    rbyte = ram_rdata[31:24];
      default: rbyte = ram_rdata[7:0];
    endcase
    case (op_q)
      OP_LB:   load_ext = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_ext = {24'd0, rbyte};
      default: load_ext = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      wdog        <= '0;
      mis_q       <= 1'b0;
      tmo_q       <= 1'b0;
      wen_q       <= 1'b0;
      load_data_q <= '0;
      load_rd_q   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q    <= mem_op;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        rd_q    <= mem_rd;
        wdog    <= '0;
        mis_q   <= mis_in;
        tmo_q   <= 1'b0;
        wen_q   <= 1'b0;
      end
      if (state == S_REQ || state == S_WAIT) wdog <= wdog + 8'd1;
      if (abort) begin
        tmo_q <= 1'b1;
        if (is_load_q) load_data_q <= '0;
      end
      if (capture) begin
        load_data_q <= load_ext;
        load_rd_q   <= rd_q;
        wen_q       <= 1'b1;
      end
    end
  end

  always_comb begin
    ram_req   = (state == S_REQ);
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ram_req) begin
      ram_we   = (op_q == OP_SW) || (op_q == OP_SB);
      ram_addr = {addr_q[ADDR_W-1:2], 2'b00};
      case (op_q)
        OP_SB: begin
          ram_be    = 4'b0001 << addr_q[1:0];
          ram_wdata = {4{wdata_q[7:0]}};
        end
        OP_SW: begin
          ram_be    = 4'hF;
          ram_wdata = wdata_q;
        end
        OP_LB, OP_LBU: ram_be = 4'b0001 << addr_q[1:0];
        default:       ram_be = 4'hF;
      endcase
    end
  end

  assign mem_busy     = accept || (state == S_REQ) || (state == S_WAIT);
  assign mem_stop_end = (state == S_DONE);
  assign load_wen     = (state == S_DONE) && wen_q;
  assign misalign_err = (state == S_DONE) && mis_q;
  assign timeout_err  = (state == S_DONE) && tmo_q;
  assign load_data    = load_data_q;
  assign load_rd      = load_rd_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver pushes expected RAM requests and
// completions derived from the access rules; a negedge monitor pops and compares.
module tb_mem_access_ctrl;
  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_op_valid = 1'b0;
  logic [2:0]  mem_op = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [4:0]  mem_rd = '0;
  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_gnt = 1'b0;
  logic        ram_rvalid = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        mem_busy, mem_stop_end, load_wen, misalign_err, timeout_err;
  logic [31:0] load_data;
  logic [4:0]  load_rd;

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mem_op_valid(mem_op_valid), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_gnt(ram_gnt), .ram_rvalid(ram_rvalid),
    .ram_rdata(ram_rdata), .mem_busy(mem_busy), .mem_stop_end(mem_stop_end),
    .load_data(load_data), .load_rd(load_rd), .load_wen(load_wen),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        st;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        wen;
    logic        mis;
    logic        tmo;
    logic        chk_data;
    logic [31:0] data;
    logic [4:0]  rd;
    int          busy;
    int          reqc;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] rdata, input int k);
    byte b;
    b = byte'(rdata >> (8 * k));
    case (op)
      3'd1:    return 32'(int'(b));
      3'd2:    return (rdata >> (8 * k)) & 32'hFF;
      default: return rdata;
    endcase
  endfunction

  // Called just after a rising edge with the DUT idle; returns just after the
  // edge at which the DUT is idle again. gd: REQ cycles before gnt; rvd: cycles
  // from gnt to rvalid (0 = same cycle).
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int gd, input int rvd, input bit noise,
                        input logic [31:0] rdata);
    bit    is_load, is_store, mis, tmo;
    int    k, tot, n_end;
    req_t  r;
    done_t d;
    is_load  = (op <= 3'd2);
    is_store = (op == 3'd3) || (op == 3'd4);
    k        = int'(addr & 32'd3);
    mis      = ((op == 3'd0) || (op == 3'd3)) && (k != 0);
    tot      = gd + 1 + (is_load ? rvd : 0);
    tmo      = (tot > int'(TMO));
    n_end    = tmo ? int'(TMO) : tot;
    if (is_load || is_store) begin
      if (mis) begin
        d.wen = 1'b0; d.mis = 1'b1; d.tmo = 1'b0; d.chk_data = 1'b0;
        d.data = '0; d.rd = '0; d.busy = 1; d.reqc = 0;
      end else begin
        if (gd + 1 <= int'(TMO)) begin
          r.we    = is_store;
          r.st    = is_store;
          r.addr  = addr & 32'hFFFF_FFFC;
          r.be    = (op == 3'd4) ? 4'(1 << k) : 4'hF;
          r.wdata = (op == 3'd4) ? (wdata & 32'hFF) * 32'h0101_0101 : wdata;
          req_q.push_back(r);
        end
        d.wen      = is_load && !tmo;
        d.mis      = 1'b0;
        d.tmo      = tmo;
        d.chk_data = is_load;
        d.data     = tmo ? 32'd0 : exp_load(op, rdata, k);
        d.rd       = rd;
        d.busy     = 1 + n_end;
        d.reqc     = (gd + 1 < int'(TMO)) ? gd + 1 : int'(TMO);
      end
      done_q.push_back(d);
    end
    mem_op_valid = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wdata; mem_rd = rd;
    @(posedge clk); #1;
    mem_op_valid = 1'b0;
    mem_op = 3'($urandom); mem_addr = $urandom; mem_wdata = $urandom; mem_rd = 5'($urandom);
    if (!(is_load || is_store)) return;
    if (!mis) begin
      for (int n = 1; n <= n_end; n++) begin
        ram_gnt   = (n == gd + 1);
        ram_rdata = $urandom;
        if (is_load && n == gd + 1 + rvd) begin
          ram_rvalid = 1'b1;
          ram_rdata  = rdata;
        end else begin
          ram_rvalid = noise && (n < gd + 1) && ($urandom_range(0, 1) == 1);
        end
        @(posedge clk); #1;
      end
    end
    // late handshake noise while the DUT is in DONE must be ignored
    ram_gnt    = noise && ($urandom_range(0, 1) == 1);
    ram_rvalid = noise && ($urandom_range(0, 1) == 1);
    ram_rdata  = $urandom;
    @(posedge clk); #1;
    ram_gnt = 1'b0; ram_rvalid = 1'b0;
  endtask

  initial begin : monitor
    int    busy_run, req_run;
    req_t  r;
    done_t d;
    busy_run = 0;
    req_run  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run = 0;
        req_run  = 0;
      end else begin
        if (ram_req && ram_gnt) begin
          chk("req_expected", 32'(req_q.size() != 0), 32'd1);
          if (req_q.size() != 0) begin
            r = req_q.pop_front();
            chk("ram_we", 32'(ram_we), 32'(r.we));
            chk("ram_addr", ram_addr, r.addr);
            if (r.st) begin
              chk("ram_be", 32'(ram_be), 32'(r.be));
              chk("ram_wdata", ram_wdata, r.wdata);
            end
          end
        end
        if (mem_stop_end) begin
          chk("done_expected", 32'(done_q.size() != 0), 32'd1);
          if (done_q.size() != 0) begin
            d = done_q.pop_front();
            chk("load_wen", 32'(load_wen), 32'(d.wen));
            chk("misalign_err", 32'(misalign_err), 32'(d.mis));
            chk("timeout_err", 32'(timeout_err), 32'(d.tmo));
            chk("busy_in_done", 32'(mem_busy), 32'd0);
            chk("busy_cycles", 32'(busy_run), 32'(d.busy));
            chk("req_cycles", 32'(req_run), 32'(d.reqc));
            if (d.chk_data) chk("load_data", load_data, d.data);
            if (d.wen) chk("load_rd", 32'(load_rd), 32'(d.rd));
          end
          busy_run = 0;
          req_run  = 0;
        end else begin
          chk("stray_pulse", {29'd0, load_wen, misalign_err, timeout_err}, 32'd0);
        end
        if (mem_busy) busy_run++;
        if (ram_req) req_run++;
      end
    end
  end

  initial begin : stimulus
    logic [2:0]  op;
    logic [31:0] addr;
    int          gd, rvd;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_mem_busy", 32'(mem_busy), 32'd0);
    chk("rst_stop_end", 32'(mem_stop_end), 32'd0);
    chk("rst_pulses", {29'd0, load_wen, misalign_err, timeout_err}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_rd", 32'(load_rd), 32'd0);
    chk("rst_ram_port", {ram_addr[27:0], ram_be}, 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'h0000_1000, 32'd0, 5'd3, 2, 3, 1'b0, 32'hDEAD_BEEF);
    run_op(3'd1, 32'h0000_1001, 32'd0, 5'd4, 0, 1, 1'b0, 32'h1234_80FF);
    run_op(3'd2, 32'h0000_1001, 32'd0, 5'd5, 1, 0, 1'b0, 32'h1234_80FF);
    run_op(3'd4, 32'h0000_2002, 32'h0000_00AB, 5'd0, 1, 0, 1'b0, 32'd0);
    run_op(3'd0, 32'h0000_1002, 32'd0, 5'd6, 0, 0, 1'b0, 32'd0);
    run_op(3'd0, 32'h0000_1004, 32'd0, 5'd7, 0, 20, 1'b0, 32'h1111_2222);

    // reset while waiting for rvalid: the late rvalid must be ignored
    req_q.push_back('{we: 1'b0, st: 1'b0, be: 4'hF, addr: 32'h0000_3000, wdata: 32'd0});
    mem_op_valid = 1'b1; mem_op = 3'd0; mem_addr = 32'h0000_3000; mem_rd = 5'd9;
    @(posedge clk); #1;
    mem_op_valid = 1'b0;
    ram_gnt = 1'b1;
    @(posedge clk); #1;
    ram_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    ram_rvalid = 1'b0;
    chk("post_rst_busy", 32'(mem_busy), 32'd0);
    chk("post_rst_req", 32'(ram_req), 32'd0);
    chk("post_rst_load_data", load_data, 32'd0);
    run_op(3'd0, 32'h0000_1008, 32'd0, 5'd10, 1, 1, 1'b0, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ((op == 3'd0 || op == 3'd3) && $urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC;
      gd  = ($urandom_range(0, 9) > 7) ? $urandom_range(5, 10) : $urandom_range(0, 3);
      rvd = ($urandom_range(0, 9) > 7) ? $urandom_range(4, 10) : $urandom_range(0, 3);
      run_op(op, addr, $urandom, 5'($urandom), gd, rvd, 1'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("pending_done", 32'(done_q.size()), 32'd0);
    chk("pending_req", 32'(req_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL sim_timeout: got stuck expected finish at %0t", $time);
    $fatal(1);
  end

endmodule
